output_interface: RTL and testbench
===================================

Name: output_interface

Overview:
- Transmit side of the pixel-stream protocol that the input interface receives.
- Reads a finished (rotated) image from the frame buffer, pixel by pixel.
- Drives it to the testbench with the same Start / H_Valid / H_Jump / 24-bit RGB framing used on the input side.
- Sits between the frame-buffer read port and the testbench output monitor.

Parameters:
- DIM_W, 11, bit width of the width/height inputs and the row/column counters.
- ADDR_W, 22, frame-buffer address width (must be >= 2*DIM_W).
- H_GAP, 2, idle cycles between rows (min 1); H_Jump_out is driven in the first of them.
- RD_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (min 1).

Ports:
- Clk_in  input  1  system clock, 100 MHz.
- Rst_in  input  1  reset; synchronous, active-high.
- frame_ready  input  1  one-cycle pulse: frame buffer holds a complete image.
- out_width  input  DIM_W  pixels per output row; sampled on an accepted frame_ready.
- out_height  input  DIM_W  rows per output frame; sampled on an accepted frame_ready.
- mem_rd_en  output  1  frame-buffer read strobe.
- mem_rd_addr  output  ADDR_W  read address = row*width + col.
- mem_rd_data  input  24  read data, valid RD_LATENCY cycles after mem_rd_en.
- Start_out  output  1  high one cycle, coincident with the first pixel of the frame.
- H_Valid_out  output  1  high during each valid pixel of a row.
- H_Jump_out  output  1  high one cycle, the cycle after each row's last pixel.
- Bmp_Data_out  output  24  RGB pixel; 0 whenever H_Valid_out is low.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse, coincident with the last row's H_Jump_out.

Behaviour:
- Reset (Rst_in high at a clock edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Counters and the delay pipeline are cleared.
  - Applies mid-frame too: the partial frame is abandoned and no frame_done is issued.
- FSM states:
  - IDLE: busy=0.
  - IDLE -> ROW on frame_ready=1 with busy=0 and both dimensions nonzero; latch width/height, row=0, col=0.
  - frame_ready is ignored while busy=1, or when width=0 or height=0 (block stays in IDLE).
  - ROW: each cycle mem_rd_en=1, mem_rd_addr=row*width+col, col++.
  - ROW -> GAP after issuing col=width-1 (col resets to 0).
  - GAP: H_GAP cycles, mem_rd_en=0.
  - GAP -> ROW (row++) if row<height-1.
  - GAP -> DRAIN on the last row.
  - DRAIN: hold until the pipeline has emitted frame_done, then go to IDLE.
- Issue-side tags:
  - pix flag on every ROW cycle.
  - first flag on row 0, col 0.
  - jump flag on the first GAP cycle.
  - last flag on the first GAP cycle of the last row.
- Output pipeline:
  - Tags pass through an (RD_LATENCY+1)-stage shift register.
  - mem_rd_data is registered once, so every output is aligned, with latency RD_LATENCY+1 from issue.
  - Start_out, H_Valid_out, H_Jump_out and frame_done come from the last pipeline stage.
  - Bmp_Data_out = registered mem_rd_data when the pix tag is set, else 0.
- busy: 1 from the cycle after frame_ready is accepted through the frame_done cycle inclusive; 0 the following cycle.
- A back-to-back frame_ready is accepted one cycle after frame_done.
- Width/height changes while busy have no effect on the current frame.
- width=1: one pixel per row, then the gap.
- Address arithmetic: unsigned and ADDR_W wide, with no wrap for legal dimensions.

Optional Feature:
- Macro: OUT_BOTTOM_UP_EN.
- Defined: rows are read from height-1 down to 0 to match BMP bottom-up storage. The first row issued is row height-1; DRAIN is entered after row 0. Framing timing is unchanged.
- Undefined: rows are read 0 up to height-1.

Test Plan:
- Reset only -> all outputs 0 for 5 cycles, with frame_ready=0.
- Default params, width=3, height=2, frame_ready at cycle 0 ->
  - mem_rd_addr 0,1,2 at cycles 1-3 and 3,4,5 at cycles 6-8.
  - H_Valid_out at cycles 3-5 and 8-10; Start_out at cycle 3.
  - H_Jump_out at cycles 6 and 11; frame_done at cycle 11.
  - busy=1 at cycles 1-11.
  - Bmp_Data_out equals the memory model contents per address.
- Same frame with frame_ready re-pulsed at cycle 5 -> ignored; output identical to the previous case.
- width=0, height=4 -> no mem_rd_en and busy stays 0; width=1, height=1 -> exactly one pixel, with Start_out, then H_Jump_out and frame_done the next cycle.
- Rst_in at cycle 7 of the width=3 frame -> all outputs 0 from cycle 8 and no frame_done; a new frame then completes normally.
- OUT_BOTTOM_UP_EN defined, width=3, height=2 -> addresses 3,4,5 then 0,1,2; framing identical to the default-params case.

Source files
------------

// File: rtl/output_interface_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : output_interface_if                                             |
// | Purpose   : Bundles the frame-buffer read port, the frame handshake and the |
// |             outgoing pixel-stream framing of output_interface.              |
// | Signals   : frame_ready, out_width, out_height   - frame request/dims      |
// |             mem_rd_en, mem_rd_addr, mem_rd_data  - frame-buffer read port  |
// |             Start_out, H_Valid_out, H_Jump_out,                             |
// |             Bmp_Data_out                         - pixel-stream framing    |
// |             busy, frame_done                     - status                  |
// | Modports  : master = output_interface side, slave = buffer/monitor side     |
// | Revision  : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
interface output_interface_if #(
  parameter int DIM_W  = 11,
  parameter int ADDR_W = 22
);
  logic              frame_ready;
  logic [DIM_W-1:0]  out_width;
  logic [DIM_W-1:0]  out_height;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [23:0]       mem_rd_data;
  logic              Start_out;
  logic              H_Valid_out;
  logic              H_Jump_out;
  logic [23:0]       Bmp_Data_out;
  logic              busy;
  logic              frame_done;

  modport master (
    input  frame_ready, out_width, out_height, mem_rd_data,
    output mem_rd_en, mem_rd_addr, Start_out, H_Valid_out, H_Jump_out,
           Bmp_Data_out, busy, frame_done
  );

  modport slave (
    output frame_ready, out_width, out_height, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, Start_out, H_Valid_out, H_Jump_out,
           Bmp_Data_out, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/output_interface.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : output_interface                                                |
// | Purpose   : Transmit side of the pixel-stream protocol. Reads a finished    |
// |             image from the frame buffer pixel by pixel and emits it with    |
// |             Start / H_Valid / H_Jump / 24-bit RGB framing.                  |
// | Ports     : Clk_in  - system clock                                          |
// |             Rst_in  - synchronous active-high reset                         |
// |             bus     - output_interface_if.master (frame handshake, read     |
// |                       port, pixel framing, busy/frame_done status)          |
// | Options   : OUT_BOTTOM_UP_EN - when defined, rows are read from height-1    |
// |             down to 0 (BMP bottom-up storage); framing timing unchanged.    |
// | Revision  : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module output_interface #(
  parameter int DIM_W      = 11,
  parameter int ADDR_W     = 22,
  parameter int H_GAP      = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                Clk_in,
  input  logic                Rst_in,
  output_interface_if.master  bus
);

  // Tag pipeline depth: read latency plus the one register on mem_rd_data.
  localparam int NSTG  = RD_LATENCY + 1;
  localparam int GAP_W = (H_GAP > 1) ? $clog2(H_GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROW   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] width_q, height_q;
  logic [DIM_W-1:0] row_q, col_q;
  logic [GAP_W-1:0] gap_q;

  logic [NSTG-1:0]  pix_q, first_q, jump_q, last_q;
  logic [23:0]      data_q;

  logic              accept;
  logic              col_end, gap_end, row_last, drain_exit;
  logic [DIM_W-1:0]  phys_row;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              tag_pix, tag_first, tag_jump, tag_last;

  // A request is only honoured from IDLE with a non-empty image.
  assign accept = (state_q == S_IDLE) && bus.frame_ready &&
                  (bus.out_width != '0) && (bus.out_height != '0);

  assign col_end  = (col_q == width_q - DIM_W'(1));
  assign gap_end  = (gap_q == GAP_W'(H_GAP - 1));
  assign row_last = (row_q == height_q - DIM_W'(1));

  // row_q counts rows in issue order; phys_row is the frame-buffer row.
`ifdef OUT_BOTTOM_UP_EN
  assign phys_row = height_q - DIM_W'(1) - row_q;
`else
  assign phys_row = row_q;
`endif

  // DRAIN ends on the frame_done cycle; if a long gap already let the last
  // tag leave the pipeline, nothing is pending and DRAIN ends at once.
  assign drain_exit = last_q[NSTG-1] || (last_q == '0);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_ROW;
      S_ROW:   if (col_end)    state_d = S_GAP;
      S_GAP:   if (gap_end)    state_d = row_last ? S_DRAIN : S_ROW;
      S_DRAIN: if (drain_exit) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    tag_pix   = 1'b0;
    tag_first = 1'b0;
    tag_jump  = 1'b0;
    tag_last  = 1'b0;
    case (state_q)
      S_ROW: begin
        rd_en     = 1'b1;
        rd_addr   = ADDR_W'(phys_row) * ADDR_W'(width_q) + ADDR_W'(col_q);
        tag_pix   = 1'b1;
        tag_first = (row_q == '0) && (col_q == '0);
      end
      S_GAP: begin
        tag_jump = (gap_q == '0);
        tag_last = (gap_q == '0) && row_last;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------- counters / dimensions
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      width_q  <= '0;
      height_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      gap_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            width_q  <= bus.out_width;
            height_q <= bus.out_height;
            row_q    <= '0;
            col_q    <= '0;
            gap_q    <= '0;
          end
        end
        S_ROW: begin
          col_q <= col_end ? '0 : col_q + DIM_W'(1);
        end
        S_GAP: begin
          if (gap_end) begin
            gap_q <= '0;
            row_q <= row_q + DIM_W'(1);
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------- alignment pipeline
  // Tags travel alongside the read so they line up with the registered data.
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      pix_q   <= '0;
      first_q <= '0;
      jump_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      pix_q   <= {pix_q[NSTG-2:0],   tag_pix};
      first_q <= {first_q[NSTG-2:0], tag_first};
      jump_q  <= {jump_q[NSTG-2:0],  tag_jump};
      last_q  <= {last_q[NSTG-2:0],  tag_last};
      data_q  <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_en    = rd_en;
  assign bus.mem_rd_addr  = rd_addr;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.Start_out    = first_q[NSTG-1];
  assign bus.H_Valid_out  = pix_q[NSTG-1];
  assign bus.H_Jump_out   = jump_q[NSTG-1];
  assign bus.frame_done   = last_q[NSTG-1];
  assign bus.Bmp_Data_out = pix_q[NSTG-1] ? data_q : 24'd0;

endmodule
`default_nettype wire

// File: tb/tb_output_interface.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : tb_output_interface                                             |
// | Purpose   : Directed self-checking bench for output_interface with a        |
// |             one-cycle-latency frame-buffer model.                           |
// | Options   : OUT_BOTTOM_UP_EN - expected addresses follow bottom-up order.   |
// | Revision  : 1.0 - initial release                                           |
// +-----------------------------------------------------------------------------+
module tb_output_interface;

  localparam int DIM_W  = 11;
  localparam int ADDR_W = 22;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  output_interface_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  output_interface #(
    .DIM_W(DIM_W), .ADDR_W(ADDR_W), .H_GAP(2), .RD_LATENCY(1)
  ) dut (
    .Clk_in (clk),
    .Rst_in (rst),
    .bus    (bus)
  );

  // Frame-buffer contents as a function of address.
  function automatic logic [23:0] pat(input logic [21:0] a);
    return {a[7:0] + 8'h11, a[7:0] ^ 8'h5A, 8'hC3 - a[7:0]};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= pat(bus.mem_rd_addr);
  end

  // {rd_en, addr, start, hvalid, hjump, bmp, busy, done}
  logic [51:0] obs;
  assign obs = {bus.mem_rd_en, bus.mem_rd_addr, bus.Start_out, bus.H_Valid_out,
                bus.H_Jump_out, bus.Bmp_Data_out, bus.busy, bus.frame_done};

  function automatic logic [21:0] addr_of(input int r, input int k, input int w, input int h);
    int pr;
`ifdef OUT_BOTTOM_UP_EN
    pr = h - 1 - r;
`else
    pr = r;
`endif
    return 22'(pr * w + k);
  endfunction

  // Expected outputs in cycle c for a frame accepted in cycle base (H_GAP=2,
  // RD_LATENCY=1): issue starts at base+1, outputs trail issue by 2 cycles.
  function automatic logic [51:0] expv(input int c, input int base, input int w, input int h);
    logic        rd, st, hv, hj, bz, dn;
    logic [21:0] ad;
    logic [23:0] bd;
    int ri, ro, lastc;
    rd = 0; st = 0; hv = 0; hj = 0; bz = 0; dn = 0; ad = '0; bd = '0;
    ri = c - base - 1;
    if (ri >= 0 && ri / (w + 2) < h && ri % (w + 2) < w) begin
      rd = 1'b1;
      ad = addr_of(ri / (w + 2), ri % (w + 2), w, h);
    end
    ro = c - base - 3;
    if (ro >= 0 && ro / (w + 2) < h) begin
      if (ro % (w + 2) < w) begin
        hv = 1'b1;
        st = (ro == 0);
        bd = pat(addr_of(ro / (w + 2), ro % (w + 2), w, h));
      end else if (ro % (w + 2) == w) begin
        hj = 1'b1;
        dn = (ro / (w + 2) == h - 1);
      end
    end
    lastc = base + 3 + (h - 1) * (w + 2) + w;
    bz = (c > base) && (c <= lastc);
    return {rd, ad, st, hv, hj, bd, bz, dn};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.frame_ready = 1'b0;
    bus.out_width = '0;
    bus.out_height = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== 52'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, 52'd0);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame;
    logic [51:0] e;
    bus.out_width = 11'd3; bus.out_height = 11'd2; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin tick(); bus.frame_ready = 1'b0; end
      e = expv(c, 0, 3, 2);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL basic_frame cyc=%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_ignore_busy;
    logic [51:0] e;
    bus.out_width = 11'd3; bus.out_height = 11'd2; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin
        tick();
        bus.frame_ready = (c == 5);
        if (c == 5) bus.out_width = 11'd7;
      end
      e = expv(c, 0, 3, 2);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL ignore_busy cyc=%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_zero_dim;
    bus.out_width = 11'd0; bus.out_height = 11'd4; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin tick(); bus.frame_ready = 1'b0; end
      checks++;
      if (obs !== 52'd0) begin
        errors++;
        $display("FAIL zero_width cyc=%0d got=%h exp=%h", c, obs, 52'd0);
      end
    end
    bus.out_width = 11'd4; bus.out_height = 11'd0; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin tick(); bus.frame_ready = 1'b0; end
      checks++;
      if (obs !== 52'd0) begin
        errors++;
        $display("FAIL zero_height cyc=%0d got=%h exp=%h", c, obs, 52'd0);
      end
    end
  endtask

  task automatic test_single_pixel;
    logic [51:0] e;
    bus.out_width = 11'd1; bus.out_height = 11'd1; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) begin tick(); bus.frame_ready = 1'b0; end
      e = expv(c, 0, 1, 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_pixel cyc=%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [51:0] e;
    bus.out_width = 11'd3; bus.out_height = 11'd2; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin
        tick();
        bus.frame_ready = 1'b0;
        rst = (c == 7);
      end
      e = (c <= 7) ? expv(c, 0, 3, 2) : 52'd0;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c, obs, e);
      end
    end
    bus.frame_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) begin tick(); bus.frame_ready = 1'b0; end
      e = expv(c, 0, 3, 2);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [51:0] e;
    bus.out_width = 11'd3; bus.out_height = 11'd2; bus.frame_ready = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) begin
        tick();
        bus.frame_ready = (c == 12);
        if (c == 2) begin bus.out_width = 11'd9; bus.out_height = 11'd5; end
        if (c == 12) begin bus.out_width = 11'd1; bus.out_height = 11'd1; end
      end
      e = expv(c, 0, 3, 2) | expv(c, 12, 1, 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ignore_busy();
    test_zero_dim();
    test_single_pixel();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
